calc_accum_unit: RTL and testbench

//  Parametrised successor of the fixed 32-bit calculator datapath: accumulator-based ALU with ADD/SUB, accumulate and

---
 rtl/calc_pkg.sv | 25 ++
 rtl/calc_accum_unit_if.sv | 27 ++
 rtl/calc_seq_mul.sv | 59 +++++
 rtl/calc_accum_unit.sv | 96 +++++++++
 tb/tb_calc_accum_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the accumulator calculator slice.
//   FN_*      : 3-bit operation codes presented on funct
//   state_e   : control FSM state encoding
//   is_mul_op : true for the multi-cycle multiply operations
package calc_pkg;

    localparam logic [2:0] FN_NOP    = 3'b000;
    localparam logic [2:0] FN_ADD    = 3'b001;
    localparam logic [2:0] FN_SUB    = 3'b010;
    localparam logic [2:0] FN_ACCADD = 3'b011;
    localparam logic [2:0] FN_ACCSUB = 3'b100;
    localparam logic [2:0] FN_MUL    = 3'b101;
    localparam logic [2:0] FN_ACCMUL = 3'b110;
    localparam logic [2:0] FN_CLR    = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_e;

    function automatic logic is_mul_op(logic [2:0] f);
        return (f == FN_MUL) || (f == FN_ACCMUL);
    endfunction

endpackage

// File: rtl/calc_accum_unit_if.sv
// Instruction/result bundle between decode, the accumulator unit and the result consumer.
//   master : instruction producer (drives in_valid/funct/imm_a/imm_b, observes results)
//   slave  : calc_accum_unit
interface calc_accum_unit_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 14
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct;
    logic [IMM_W-1:0] imm_a;
    logic [IMM_W-1:0] imm_b;
    logic [WIDTH-1:0] accum_out;
    logic             res_valid;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, funct, imm_a, imm_b,
        input  in_ready, accum_out, res_valid, ovf, busy
    );

    modport slave (
        input  in_valid, funct, imm_a, imm_b,
        output in_ready, accum_out, res_valid, ovf, busy
    );
endinterface

// File: rtl/calc_seq_mul.sv
// Iterative shift-add multiplier, one multiplier bit (LSB first) per clock.
//   clk, reset    : clock, asynchronous active-low reset
//   start         : load operands and begin (IMM_W iterations follow)
//   multiplicand  : WIDTH-bit operand
//   multiplier    : IMM_W-bit operand
//   done          : high in the cycle whose closing edge performs the last iteration
//   product       : full product as it stands after that edge (valid while done=1)
module calc_seq_mul #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 14
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [WIDTH-1:0]       multiplicand,
    input  logic [IMM_W-1:0]       multiplier,
    output logic                   done,
    output logic [WIDTH+IMM_W-1:0] product
);
    localparam int unsigned PW = WIDTH + IMM_W;
    localparam int unsigned CW = $clog2(IMM_W + 1);

    logic [PW-1:0]    mcand_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    acc_next;
    logic [IMM_W-1:0] mplier_q;
    logic [CW-1:0]    cnt_q;

    always_comb begin
        acc_next = acc_q;
        if (mplier_q[0]) begin
            acc_next = acc_q + mcand_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else if (start) begin
            mcand_q  <= PW'(multiplicand);
            acc_q    <= '0;
            mplier_q <= multiplier;
            cnt_q    <= CW'(IMM_W);
        end else if (cnt_q != '0) begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - 1'b1;
        end
    end

    // Presenting the next-state sum lets the consumer capture the result on the final edge.
    assign done    = (cnt_q == CW'(1));
    assign product = acc_next;

endmodule

// File: rtl/calc_accum_unit.sv
// Accumulator ALU: ADD/SUB, accumulate add/sub, and multi-cycle shift-add multiply.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : slave side of calc_accum_unit_if (instruction in, accumulator/ovf/res_valid out)
module calc_accum_unit
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IMM_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    calc_accum_unit_if.slave  bus
);
    state_e                   state_q;
    logic [WIDTH-1:0]         accum_q;
    logic                     ovf_q;
    logic                     res_valid_q;

    logic [WIDTH-1:0]         a_ext;
    logic [WIDTH-1:0]         b_ext;
    logic [WIDTH:0]           alu_wide;
    logic                     mul_start;
    logic                     mul_done;
    logic [WIDTH+IMM_W-1:0]   mul_product;

    assign a_ext = WIDTH'(bus.imm_a);
    assign b_ext = WIDTH'(bus.imm_b);

    // Single-cycle ops: the extra top bit carries carry-out or borrow.
    always_comb begin
        alu_wide = '0;
        case (bus.funct)
            FN_NOP:    alu_wide = {1'b0, accum_q};
            FN_ADD:    alu_wide = {1'b0, a_ext} + {1'b0, b_ext};
            FN_SUB:    alu_wide = {1'b0, a_ext} - {1'b0, b_ext};
            FN_ACCADD: alu_wide = {1'b0, accum_q} + {1'b0, a_ext};
            FN_ACCSUB: alu_wide = {1'b0, accum_q} - {1'b0, a_ext};
            default:   alu_wide = '0;
        endcase
    end

    assign mul_start = bus.in_valid && (state_q == ST_IDLE) && is_mul_op(bus.funct);

    calc_seq_mul #(
        .WIDTH (WIDTH),
        .IMM_W (IMM_W)
    ) u_mul (
        .clk          (clk),
        .reset        (reset),
        .start        (mul_start),
        .multiplicand ((bus.funct == FN_MUL) ? b_ext : accum_q),
        .multiplier   (bus.imm_a),
        .done         (mul_done),
        .product      (mul_product)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            accum_q     <= '0;
            ovf_q       <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        if (is_mul_op(bus.funct)) begin
                            state_q <= ST_MUL;
                        end else begin
                            accum_q     <= alu_wide[WIDTH-1:0];
                            ovf_q       <= alu_wide[WIDTH];
                            res_valid_q <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        accum_q     <= mul_product[WIDTH-1:0];
                        ovf_q       <= |mul_product[WIDTH+IMM_W-1:WIDTH];
                        res_valid_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.busy      = (state_q == ST_MUL);
    assign bus.accum_out = accum_q;
    assign bus.ovf       = ovf_q;
    assign bus.res_valid = res_valid_q;

endmodule

// File: tb/tb_calc_accum_unit.sv
// Self-checking bench for calc_accum_unit (WIDTH=32, IMM_W=14) with a behavioural model.
module tb_calc_accum_unit;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned IMM_W = 14;
    localparam int MUL_LAT = IMM_W + 1;  // negedge index after acceptance where res_valid shows

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] m_acc;
    bit          m_ovf;

    calc_accum_unit_if #(.WIDTH(WIDTH), .IMM_W(IMM_W)) bus ();

    calc_accum_unit #(.WIDTH(WIDTH), .IMM_W(IMM_W)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic on the operation definitions.
    task automatic model_step(input logic [2:0] f, input int unsigned a, input int unsigned b);
        longint unsigned la, lb, lacc, full;
        la = a; lb = b; lacc = m_acc;
        case (f)
            3'd0: m_ovf = 0;
            3'd1: begin full = la + lb;   m_acc = full[31:0]; m_ovf = full[32]; end
            3'd2: begin full = la - lb;   m_acc = full[31:0]; m_ovf = lb > la; end
            3'd3: begin full = lacc + la; m_acc = full[31:0]; m_ovf = full[32]; end
            3'd4: begin full = lacc - la; m_acc = full[31:0]; m_ovf = la > lacc; end
            3'd5: begin full = la * lb;   m_acc = full[31:0]; m_ovf = (full >> 32) != 0; end
            3'd6: begin full = lacc * la; m_acc = full[31:0]; m_ovf = (full >> 32) != 0; end
            default: begin m_acc = 0; m_ovf = 0; end
        endcase
    endtask

    // Issue one instruction (called just after a negedge); returns observations at the
    // negedge where res_valid appears. lat = -1 on timeout.
    task automatic run_op(input logic [2:0] f, input int unsigned a, input int unsigned b,
                          output int lat, output logic [31:0] acc, output logic o,
                          output int stall, output bit held);
        logic [31:0] pre;
        int w;
        bus.funct = f; bus.imm_a = IMM_W'(a); bus.imm_b = IMM_W'(b); bus.in_valid = 1'b1;
        w = 0;
        while (!bus.in_ready && w < 40) begin @(negedge clk); w++; end
        pre = bus.accum_out;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat = 0; stall = 0; held = 1;
        forever begin
            @(negedge clk);
            lat++;
            if (!bus.in_ready) stall++;
            if (bus.res_valid) break;
            if (bus.accum_out !== pre) held = 0;
            if (lat >= 40) begin lat = -1; break; end
        end
        acc = bus.accum_out; o = bus.ovf;
        model_step(f, a, b);
    endtask

    task automatic test_reset();
        int lat, st; logic [31:0] acc; logic o; bit h;
        run_op(3'd1, 100, 23, lat, acc, o, st, h);
        n_cmp++; if (acc !== 32'd123) begin n_err++; $display("FAIL pre_reset_add: got %h want %h", acc, 32'd123); end
        rst_n = 1'b0; #1;
        m_acc = 0; m_ovf = 0;
        n_cmp++; if (bus.accum_out !== 32'd0) begin n_err++; $display("FAIL reset_accum: got %h want 0", bus.accum_out); end
        n_cmp++; if (bus.ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", bus.ovf); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_add_sub();
        int lat, st; logic [31:0] acc; logic o; bit h;
        run_op(3'd1, 5, 7, lat, acc, o, st, h);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL add_latency: got %0d want 1", lat); end
        n_cmp++; if (acc !== 32'd12 || o !== 1'b0) begin n_err++; $display("FAIL add_5_7: got %h/%b want 0000000c/0", acc, o); end
        run_op(3'd4, 20, 0, lat, acc, o, st, h);
        n_cmp++; if (acc !== 32'hFFFFFFF8 || o !== 1'b1) begin n_err++; $display("FAIL accsub_20: got %h/%b want fffffff8/1", acc, o); end
        @(negedge clk);
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL res_valid_single_pulse: got %b want 0", bus.res_valid); end
    endtask

    task automatic test_mul();
        int lat, st; logic [31:0] acc; logic o; bit h;
        run_op(3'd5, 300, 200, lat, acc, o, st, h);
        n_cmp++; if (st !== IMM_W) begin n_err++; $display("FAIL mul_stall_cycles: got %0d want %0d", st, IMM_W); end
        n_cmp++; if (lat !== MUL_LAT) begin n_err++; $display("FAIL mul_latency: got %0d want %0d", lat, MUL_LAT); end
        n_cmp++; if (h !== 1'b1) begin n_err++; $display("FAIL mul_accum_held: got %b want 1", h); end
        n_cmp++; if (acc !== 32'd60000 || o !== 1'b0) begin n_err++; $display("FAIL mul_300_200: got %h/%b want 0000ea60/0", acc, o); end
    endtask

    task automatic test_mul_chain();
        int lat, st; logic [31:0] acc; logic o; bit h;
        run_op(3'd5, 16383, 16383, lat, acc, o, st, h);
        n_cmp++; if (acc !== 32'h0FFF8001 || o !== 1'b0) begin n_err++; $display("FAIL mul_max: got %h/%b want 0fff8001/0", acc, o); end
        run_op(3'd6, 16, 0, lat, acc, o, st, h);
        n_cmp++; if (acc !== 32'hFFF80010 || o !== 1'b0) begin n_err++; $display("FAIL accmul_16_a: got %h/%b want fff80010/0", acc, o); end
        run_op(3'd6, 16, 0, lat, acc, o, st, h);
        n_cmp++; if (acc !== 32'hFF800100 || o !== 1'b1) begin n_err++; $display("FAIL accmul_16_b: got %h/%b want ff800100/1", acc, o); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, st, pulses; logic [31:0] acc; logic o; bit h;
        bus.funct = 3'd5; bus.imm_a = 14'd300; bus.imm_b = 14'd200; bus.in_valid = 1'b1;
        @(posedge clk); #1; bus.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL mid_mul_busy: got %b want 1", bus.busy); end
        rst_n = 1'b0; #1;
        m_acc = 0; m_ovf = 0;
        n_cmp++; if (bus.accum_out !== 32'd0 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_err++; $display("FAIL mid_mul_reset: got acc=%h rv=%b rdy=%b want 0/0/1", bus.accum_out, bus.res_valid, bus.in_ready);
        end
        @(negedge clk); rst_n = 1'b1;
        run_op(3'd1, 1, 1, lat, acc, o, st, h);
        n_cmp++; if (lat !== 1 || acc !== 32'd2) begin n_err++; $display("FAIL add_after_reset: got lat=%0d acc=%h want 1/00000002", lat, acc); end
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.res_valid || bus.accum_out !== 32'd2) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL aborted_mul_silent: got %0d stray events want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] mexp, got_acc [2];
        int got_lat [2];
        int np, j, acc_lat;
        bit accepting;
        logic [2:0] ops [3];
        int unsigned oa [3], ob [3];
        int unsigned a, b;
        a = $urandom_range(1, 16383); b = $urandom_range(1, 16383);
        bus.funct = 3'd5; bus.imm_a = IMM_W'(a); bus.imm_b = IMM_W'(b); bus.in_valid = 1'b1;
        @(posedge clk); #1;
        model_step(3'd5, a, b); mexp = m_acc;
        bus.funct = 3'd1; bus.imm_a = 14'd1; bus.imm_b = 14'd2;  // held through the multiply
        np = 0; j = 0; acc_lat = -1; accepting = 0;
        while (np < 2 && j < 40) begin
            @(negedge clk); j++;
            if (accepting) bus.in_valid = 1'b0;
            if (bus.res_valid) begin got_acc[np] = bus.accum_out; got_lat[np] = j; np++; end
            if (bus.in_valid && bus.in_ready && !accepting) begin accepting = 1; acc_lat = j; end
        end
        bus.in_valid = 1'b0;
        model_step(3'd1, 1, 2);
        n_cmp++; if (np !== 2) begin n_err++; $display("FAIL held_pulses: got %0d want 2", np); end
        else begin
            n_cmp++; if (got_acc[0] !== mexp || got_lat[0] !== MUL_LAT) begin
                n_err++; $display("FAIL held_mul_result: got %h@%0d want %h@%0d", got_acc[0], got_lat[0], mexp, MUL_LAT);
            end
            n_cmp++; if (got_acc[1] !== 32'd3 || got_lat[1] !== MUL_LAT + 1) begin
                n_err++; $display("FAIL held_add_result: got %h@%0d want 00000003@%0d", got_acc[1], got_lat[1], MUL_LAT + 1);
            end
        end
        n_cmp++; if (acc_lat !== MUL_LAT) begin n_err++; $display("FAIL held_accept_point: got %0d want %0d", acc_lat, MUL_LAT); end
        ops[0] = 3'd1; ops[1] = 3'd2; ops[2] = 3'd7;
        for (int i = 0; i < 3; i++) begin oa[i] = $urandom_range(0, 16383); ob[i] = $urandom_range(0, 16383); end
        np = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(negedge clk);
                model_step(ops[i-1], oa[i-1], ob[i-1]);
                if (bus.res_valid) np++;
                n_cmp++; if (bus.accum_out !== m_acc || bus.ovf !== m_ovf) begin
                    n_err++; $display("FAIL b2b_op%0d: got %h/%b want %h/%b", i - 1, bus.accum_out, bus.ovf, m_acc, m_ovf);
                end
            end
            if (i < 3) begin
                bus.funct = ops[i]; bus.imm_a = IMM_W'(oa[i]); bus.imm_b = IMM_W'(ob[i]); bus.in_valid = 1'b1;
            end else bus.in_valid = 1'b0;
        end
        n_cmp++; if (np !== 3 || bus.accum_out !== 32'd0 || bus.ovf !== 1'b0) begin
            n_err++; $display("FAIL b2b_final: got pulses=%0d acc=%h ovf=%b want 3/0/0", np, bus.accum_out, bus.ovf);
        end
    endtask

    task automatic test_random();
        int lat, st, elat; logic [31:0] acc; logic o; bit h;
        logic [2:0] f; int unsigned a, b;
        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0: a = 0;
                1: a = 16383;
                default: a = $urandom_range(0, 16383);
            endcase
            b = $urandom_range(0, 16383);
            elat = (f == 3'd5 || f == 3'd6) ? MUL_LAT : 1;
            run_op(f, a, b, lat, acc, o, st, h);
            n_cmp++; if (lat !== elat || acc !== m_acc || o !== m_ovf) begin
                n_err++; $display("FAIL rand_%0d f=%0d a=%0d b=%0d: got %h/%b@%0d want %h/%b@%0d",
                                  i, f, a, b, acc, o, lat, m_acc, m_ovf, elat);
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.funct = 3'd0; bus.imm_a = '0; bus.imm_b = '0;
        m_acc = 0; m_ovf = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_add_sub();
        test_mul();
        test_mul_chain();
        test_reset_mid_mul();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
